mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-003 in_valid  in  1  AGEX latch holds a valid instruction.
REQ-004 in_is_load / in_is_store  in  1 each  instruction class from AGEX op decode; both high treated as store.
REQ-005 in_wr_reg  in  1  instruction writes rd.
REQ-006 in_rd  in  5  destination register.
REQ-007 in_pc  in  32  instruction PC.
REQ-008 in_arith  in  32  ALU result; for stores, the store data.
REQ-009 in_memaddr  in  32  effective byte address for load/store.
REQ-010 in_ready  out  1  stage can accept this cycle; 0 = upstream stall.
REQ-011 dmem_req / dmem_we  out  1 each  data-memory request / write enable.
REQ-012 dmem_addr / dmem_wdata  out  32 each  word address (bits[1:0]=00) / write data.
REQ-013 dmem_ack  in  1  memory completed request this cycle; dmem_rdata  in  32  load data, valid with ack.
REQ-014 out_valid, out_wr_reg  out  1 each; out_rd  out  5; out_pc, out_result  out  32 each  MEM latch toward WB.
REQ-015 out_misalign  out  1  retired access was misaligned (see Configuration).
REQ-016 fwd_valid  out  1; fwd_rd  out  5; fwd_value  out  32  forwarding to AGEX/DE.
REQ-017 stall_cycles  out  32  count of cycles with in_ready=0.

Function
REQ-018 FSM states IDLE, ACCESS; in_ready SHALL equal (state==IDLE).
REQ-019 IDLE, in_valid, not load/store: latch updated at that edge; out_valid=1 next cycle; out_result=in_arith; out_wr_reg=in_wr_reg.
REQ-020 IDLE, in_valid, load or store: capture pc/rd/wr_reg/addr/data/we into hold regs, go ACCESS; out_valid=0 next cycle.
REQ-021 ACCESS: dmem_req=1, dmem_we/addr/wdata from hold regs, held stable until dmem_ack sampled high.
REQ-022 ACCESS and dmem_ack: go IDLE; latch updated at that edge, out_valid=1 next cycle; load: out_result=dmem_rdata, out_wr_reg=hold wr_reg; store: out_result=0, out_wr_reg=0.
REQ-023 Minimum load/store latency: accept at edge N, req cycles N+1.., ack at cycle N+k, result visible cycle N+k+1; in_ready high again cycle N+k+1.
REQ-024 dmem_ack while in IDLE SHALL be ignored; dmem_req=0 in IDLE.
REQ-025 in_valid=0 in IDLE: out_valid=0 next cycle, other latch fields hold.
REQ-026 out_valid is a one-cycle pulse per retired instruction; no backpressure from WB.
REQ-027 fwd_valid = out_valid & out_wr_reg & (out_rd!=0); fwd_rd=out_rd; fwd_value=out_result.
REQ-028 stall_cycles +1 each cycle in_ready=0; saturates at 0xFFFFFFFF (no wrap).

Reset
REQ-029 reset=0: state=IDLE, all out_*, hold regs, stall_cycles =0; dmem_req=0 from next cycle.
REQ-030 Reset mid-ACCESS abandons request; a late dmem_ack after reset is ignored per REQ-024.

Configuration
REQ-031 Macro MEM_MISALIGN_TRAP_EN defined: load/store with in_memaddr[1:0]!=0 goes neither to ACCESS nor issues dmem_req; retires next cycle with out_valid=1, out_misalign=1, out_wr_reg=0, out_result=in_memaddr.
REQ-032 Macro undefined: address bits[1:0] forced to 00 and access proceeds normally; out_misalign tied 0.

Verification
REQ-033 ADD in_arith=0x5,rd=3 in IDLE -> next cycle out_valid=1,out_result=0x5,fwd_valid=1,fwd_rd=3; in_ready stays 1.
REQ-034 LW addr=0x100, ack 3 cycles after req rises, rdata=0xDEADBEEF -> dmem_addr=0x100 held 3 cycles, in_ready=0 those 3 cycles, out_result=0xDEADBEEF cycle after ack, stall_cycles=3.
REQ-035 SW addr=0x204,data=0x1234, ack same first req cycle -> dmem_we=1,wdata=0x1234 one cycle; out_valid=1,out_wr_reg=0 next cycle.
REQ-036 reset=0 during ACCESS, then ack next cycle -> dmem_req=0, out_valid=0, stall_cycles=0, no retirement.
REQ-037 LW addr=0x102: with MEM_MISALIGN_TRAP_EN -> no dmem_req, out_misalign=1,out_result=0x102; without -> dmem_addr=0x100, out_misalign=0.
REQ-038 stall_cycles preloaded near 0xFFFFFFFE via 3 stall cycles -> reads 0xFFFFFFFF, does not wrap.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: passes ALU ops straight to the MEM latch and runs one blocking data-memory
// access per load/store. Define MEM_MISALIGN_TRAP_EN to retire misaligned accesses as traps.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic        in_wr_reg,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_arith,
  input  logic [31:0] in_memaddr,
  output logic        in_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic        out_wr_reg,
  output logic [4:0]  out_rd,
  output logic [31:0] out_pc,
  output logic [31:0] out_result,
  output logic        out_misalign,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_value,
  output logic [31:0] stall_cycles
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RW      = 5;
  localparam int unsigned WADDR_W = XLEN - 2;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t               state_q;
  logic [XLEN-1:0]      hold_pc;
  logic [RW-1:0]        hold_rd;
  logic                 hold_wr_reg;
  logic [WADDR_W-1:0]   hold_addr;
  logic [XLEN-1:0]      hold_wdata;
  logic                 hold_we;
  logic [XLEN-1:0]      stall_cnt;
  logic                 is_mem;
  logic                 trap;

  assign is_mem = in_is_load | in_is_store;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = is_mem & (in_memaddr[1:0] != 2'b00);
`else
  // Byte offset is dropped: accesses are word-aligned by truncation.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^in_memaddr[1:0];
  assign trap            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      hold_pc      <= '0;
      hold_rd      <= '0;
      hold_wr_reg  <= 1'b0;
      hold_addr    <= '0;
      hold_wdata   <= '0;
      hold_we      <= 1'b0;
      out_valid    <= 1'b0;
      out_wr_reg   <= 1'b0;
      out_rd       <= '0;
      out_pc       <= '0;
      out_result   <= '0;
      out_misalign <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (is_mem && !trap) begin
              state_q     <= ACCESS;
              hold_pc     <= in_pc;
              hold_rd     <= in_rd;
              hold_wr_reg <= in_wr_reg;
              hold_addr   <= in_memaddr[XLEN-1:2];
              hold_wdata  <= in_arith;
              hold_we     <= in_is_store;
            end else begin
              // ALU op or trapped misaligned access retires immediately.
              out_valid    <= 1'b1;
              out_pc       <= in_pc;
              out_rd       <= in_rd;
              out_wr_reg   <= in_wr_reg & ~trap;
              out_result   <= trap ? in_memaddr : in_arith;
              out_misalign <= trap;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            state_q      <= IDLE;
            out_valid    <= 1'b1;
            out_pc       <= hold_pc;
            out_rd       <= hold_rd;
            out_wr_reg   <= hold_we ? 1'b0 : hold_wr_reg;
            out_result   <= hold_we ? '0 : dmem_rdata;
            out_misalign <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (state_q == ACCESS && stall_cnt != '1)
        stall_cnt <= stall_cnt + XLEN'(1);
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign dmem_req     = (state_q == ACCESS);
  assign dmem_we      = hold_we;
  assign dmem_addr    = {hold_addr, 2'b00};
  assign dmem_wdata   = hold_wdata;
  assign stall_cycles = stall_cnt;

  assign fwd_valid = out_valid & out_wr_reg & (out_rd != '0);
  assign fwd_rd    = out_rd;
  assign fwd_value = out_result;

endmodule
